// File: rtl/dm_bus_ctrl.sv
// M-stage memory bus controller: one request at a time, IDLE->BUSY->DONE, stall held until DONE.
// Latency: 2 stall cycles with an immediate bus_ack, +1 per wait cycle; bus_ack gives backpressure and TIMEOUT bounds it.
module dm_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rd_word,
  output logic        rd_valid,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_byteen;
  logic [31:0] rd_word_q;
  logic        rd_valid_q;
  logic        err_q;
  logic        accept, zero_be, ack_hit, tmo_hit;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    accept  = 1'b0;
    zero_be = 1'b0;
    ack_hit = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (|req_byteen) begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_d = BUSY;
          end else begin
            zero_be = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        // ack wins over a timeout landing in the same cycle
        if (bus_ack) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_byteen <= '0;
      rd_word_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= zero_be | tmo_hit;
      rd_valid_q <= (ack_hit | tmo_hit) & ~lat_we;
      if (accept) begin
        lat_we     <= req_we;
        lat_addr   <= req_addr & 32'hFFFF_FFFC;
        lat_wdata  <= req_wdata;
        lat_byteen <= req_byteen;
        cnt_q      <= '0;
      end else if (state_q == BUSY && !bus_ack && !tmo_hit) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (ack_hit && !lat_we) begin
        rd_word_q <= bus_rdata;
      end else if (tmo_hit) begin
        rd_word_q <= '0;
      end
    end
  end

  assign bus_req    = (state_q == BUSY);
  assign bus_we     = lat_we;
  assign bus_addr   = lat_addr;
  assign bus_wdata  = lat_wdata;
  assign bus_byteen = lat_byteen;
  assign rd_word    = rd_word_q;
  assign rd_valid   = rd_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Directed bench for dm_bus_ctrl: load, store with waits, timeout, ack/timeout race, zero byteen, reset mid-BUSY.
module tb_dm_bus_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rd_word;
  logic        rd_valid;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int scnt;

  dm_bus_ctrl #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_byteen (req_byteen),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rd_word    (rd_word),
    .rd_valid   (rd_valid),
    .err        (err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byteen (bus_byteen),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs change 2ns after the rising edge, outputs are sampled 1ns later
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_byteen = '0; req_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_rd_word", rd_word, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_err", err, 0);
    #9 reset = 1'b1;

    // zero-wait load
    cyc();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_1006; req_byteen = 4'b0100;
    #1;
    chk("ld_idle_stall", stall, 1);
    chk("ld_idle_bus_req", bus_req, 0);
    cyc();
    req_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hAABB_CCDD;
    #1;
    chk("ld_busy_req", bus_req, 1);
    chk("ld_busy_addr", bus_addr, 32'h0000_1004);
    chk("ld_busy_byteen", bus_byteen, 4'b0100);
    chk("ld_busy_we", bus_we, 0);
    chk("ld_busy_stall", stall, 1);
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_done_stall", stall, 0);
    chk("ld_done_req", bus_req, 0);
    chk("ld_done_rd_valid", rd_valid, 1);
    chk("ld_done_rd_word", rd_word, 32'hAABB_CCDD);
    chk("ld_done_err", err, 0);
    cyc();
    bus_ack = 1'b1;
    #1;
    chk("idle_ack_ignored_word", rd_word, 32'hAABB_CCDD);
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_req", bus_req, 0);

    // store, ack on the fourth BUSY cycle
    cyc();
    bus_ack = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
    req_byteen = 4'b1100; req_wdata = 32'h1234_0000;
    #1;
    scnt = (stall === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      req_valid = 1'b0; req_wdata = 32'hFFFF_FFFF; req_addr = 32'hFFFF_FFFF;
      bus_ack = (i == 3);
      #1;
      if (stall === 1'b1) scnt++;
      chk("st_busy_req", bus_req, 1);
      chk("st_busy_we", bus_we, 1);
      chk("st_busy_addr", bus_addr, 32'h10);
      chk("st_busy_wdata", bus_wdata, 32'h1234_0000);
      chk("st_busy_byteen", bus_byteen, 4'b1100);
    end
    cyc();
    bus_ack = 1'b0;
    #1;
    if (stall === 1'b1) scnt++;
    chk("st_stall_cycles", scnt, 5);
    chk("st_done_rd_valid", rd_valid, 0);
    chk("st_rd_word_kept", rd_word, 32'hAABB_CCDD);
    chk("st_done_err", err, 0);

    // load timeout
    cyc();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_byteen = 4'b1111;
    #1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      req_valid = 1'b0;
      #1;
      chk("tmo_busy_req", bus_req, 1);
      chk("tmo_busy_err", err, 0);
    end
    cyc();
    #1;
    chk("tmo_done_req", bus_req, 0);
    chk("tmo_done_stall", stall, 0);
    chk("tmo_done_err", err, 1);
    chk("tmo_done_rd_word", rd_word, 0);

    // ack on the same cycle the timeout would fire
    cyc();
    #1;
    chk("tmo_after_err", err, 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30; req_byteen = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      cyc();
      req_valid = 1'b0;
      bus_ack = (i == 15); bus_rdata = 32'h5555_AAAA;
      #1;
      chk("race_busy_req", bus_req, 1);
    end
    cyc();
    bus_ack = 1'b0;
    #1;
    chk("race_err", err, 0);
    chk("race_rd_word", rd_word, 32'h5555_AAAA);
    chk("race_rd_valid", rd_valid, 1);

    // zero byteen request
    cyc();
    req_valid = 1'b1; req_byteen = 4'b0000; req_addr = 32'h44;
    #1;
    chk("zbe_stall", stall, 0);
    chk("zbe_req", bus_req, 0);
    cyc();
    req_valid = 1'b0;
    #1;
    chk("zbe_err", err, 1);
    chk("zbe_req_next", bus_req, 0);
    chk("zbe_stall_next", stall, 0);
    cyc();
    #1;
    chk("zbe_err_clear", err, 0);
    chk("zbe_req_after", bus_req, 0);

    // reset mid-BUSY, late ack ignored
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_byteen = 4'b1111;
    cyc();
    req_valid = 1'b0; bus_rdata = 32'h9999_9999;
    #1;
    chk("rb_busy_req", bus_req, 1);
    cyc();
    #1;
    reset = 1'b0;
    #1;
    chk("rb_req", bus_req, 0);
    chk("rb_stall", stall, 0);
    chk("rb_addr", bus_addr, 0);
    chk("rb_byteen", bus_byteen, 0);
    chk("rb_rd_word", rd_word, 0);
    chk("rb_err", err, 0);
    chk("rb_rd_valid", rd_valid, 0);
    #1 reset = 1'b1;
    cyc();
    cyc();
    bus_ack = 1'b1;
    #1;
    chk("rb_late_req", bus_req, 0);
    chk("rb_late_stall", stall, 0);
    cyc();
    bus_ack = 1'b0;
    #1;
    chk("rb_late_rd_word", rd_word, 0);
    chk("rb_late_rd_valid", rd_valid, 0);
    chk("rb_late_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
